// File: rtl/jtcps1_prog_merge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtcps1_prog_merge_pkg
//  Description : Shared lane-mask encodings and byte placement helper for the
//                ROM-download byte merger.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtcps1_prog_merge_pkg;

    // Active-low byte-lane masks as presented on prog_mask / wr_dsn
    localparam logic [1:0] MASK_LO   = 2'b10;   // lane [7:0] only
    localparam logic [1:0] MASK_HI   = 2'b01;   // lane [15:8] only
    localparam logic [1:0] MASK_WORD = 2'b00;   // both lanes

    // Put a byte into the lane(s) enabled by an active-low mask; other lanes are zero
    function automatic logic [15:0] place_byte(input logic [7:0] b, input logic [1:0] mask);
        logic [15:0] w;
        w = 16'h0000;
        if (!mask[0]) w[7:0]  = b;
        if (!mask[1]) w[15:8] = b;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtcps1_prog_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : jtcps1_prog_fifo
//  Description : Small synchronous FIFO holding merged SDRAM write entries.
//                Push on full is accepted only together with a pop; pop on
//                empty is ignored. Head entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtcps1_prog_fifo #(
    parameter int DW = 42,
    parameter int LG = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 1 << LG;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [LG-1:0] wr_ptr_q, wr_ptr_d;
    logic [LG-1:0] rd_ptr_q, rd_ptr_d;
    logic [LG:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (LG+1)'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap modulo depth) and occupancy count
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + LG'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + LG'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (LG+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (LG+1)'(1);
        end
    end

    // State registers; reset clears contents so the head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtcps1_prog_merge.sv
`default_nettype none
// ============================================================================
//  Module      : jtcps1_prog_merge
//  Description : Merges ROM-download byte writes into 16-bit SDRAM writes.
//                Holds one pending half-word, pairs complementary lanes of
//                the same address/bank, flushes lone bytes after an idle
//                timeout or when the download ends, and queues results in a
//                small FIFO towards the SDRAM programming port.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtcps1_prog_merge
    import jtcps1_prog_merge_pkg::*;
#(
    parameter int AW      = 22,
    parameter int FIFO_LG = 2,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [1:0]    prog_mask,
    input  logic [1:0]    prog_bank,
    input  logic          prog_we,
    output logic          sdram_ack,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic [1:0]    wr_dsn,
    output logic [1:0]    wr_bank,
    input  logic          wr_ack,
    output logic          busy
);

    localparam int         DW  = AW + 20;          // {bank, addr, dsn, data}
    localparam logic [3:0] TMO = 4'(TIMEOUT);

    logic          sdram_ack_q, sdram_ack_d;
    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [1:0]    pend_bank_q, pend_bank_d;
    logic [15:0]   pend_data_q, pend_data_d;
    logic [1:0]    pend_dsn_q, pend_dsn_d;
    logic [3:0]    tmr_q, tmr_d;

    logic          accept, pair_ok, flush_cond, flush_ok;
    logic [15:0]   new_data;
    logic          fifo_push, fifo_empty, fifo_full;
    logic [DW-1:0] fifo_din, fifo_dout;

    // Accept handshake, merge/flush decisions and timeout counter next-state
    always_comb begin
        accept     = prog_we & ~sdram_ack_q & downloading & ~fifo_full;
        new_data   = place_byte(prog_data, prog_mask);
        pair_ok    = pend_valid_q && (pend_addr_q == prog_addr) && (pend_bank_q == prog_bank)
                     && ((pend_dsn_q & prog_mask) == MASK_WORD);
        flush_cond = pend_valid_q & ((tmr_q == TMO) | ~downloading);
        // a full FIFO only takes the flush if the controller pops in the same cycle
        flush_ok   = ~fifo_full | wr_ack;

        sdram_ack_d  = accept;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_bank_d  = pend_bank_q;
        pend_data_d  = pend_data_q;
        pend_dsn_d   = pend_dsn_q;
        tmr_d        = tmr_q;
        fifo_push    = 1'b0;
        fifo_din     = {pend_bank_q, pend_addr_q, pend_dsn_q, pend_data_q};

        if (accept) begin
            tmr_d = 4'd0;
            if (pend_valid_q && pair_ok) begin
                fifo_push    = 1'b1;
                fifo_din     = {pend_bank_q, pend_addr_q, MASK_WORD, pend_data_q | new_data};
                pend_valid_d = 1'b0;
            end else begin
                // pending (if any) leaves as a partial word; new byte takes its place
                fifo_push    = pend_valid_q;
                pend_valid_d = 1'b1;
                pend_addr_d  = prog_addr;
                pend_bank_d  = prog_bank;
                pend_data_d  = new_data;
                pend_dsn_d   = prog_mask;
            end
        end else if (flush_cond && flush_ok) begin
            fifo_push    = 1'b1;
            pend_valid_d = 1'b0;
            tmr_d        = 4'd0;
        end else if (pend_valid_q && tmr_q != TMO) begin
            tmr_d = tmr_q + 4'd1;
        end
    end

    // Handshake, pending register and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_ack_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_bank_q  <= '0;
            pend_data_q  <= '0;
            pend_dsn_q   <= '0;
            tmr_q        <= '0;
        end else begin
            sdram_ack_q  <= sdram_ack_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_bank_q  <= pend_bank_d;
            pend_data_q  <= pend_data_d;
            pend_dsn_q   <= pend_dsn_d;
            tmr_q        <= tmr_d;
        end
    end

    jtcps1_prog_fifo #(
        .DW (DW),
        .LG (FIFO_LG)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (wr_ack),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign sdram_ack = sdram_ack_q;
    assign wr_req    = ~fifo_empty;
    assign {wr_bank, wr_addr, wr_dsn, wr_data} = fifo_dout;
    assign busy      = pend_valid_q | ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_jtcps1_prog_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtcps1_prog_merge
//  Description : Self-checking bench for jtcps1_prog_merge: directed
//                scenarios plus randomized byte streams against a
//                transaction-level merge model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtcps1_prog_merge;

    localparam int AW      = 22;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    bank;
        logic [15:0]   data;
        logic [1:0]    dsn;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    bank;
        logic [7:0]    d;
        logic [1:0]    mask;
        int            cyc;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          downloading = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [7:0]    prog_data = '0;
    logic [1:0]    prog_mask = 2'b11;
    logic [1:0]    prog_bank = '0;
    logic          prog_we = 1'b0;
    logic          sdram_ack;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [1:0]    wr_dsn;
    logic [1:0]    wr_bank;
    logic          wr_ack = 1'b0;
    logic          busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ack_mode = 0;   // 0 manual, 1 random, 2 always
    wr_t  got[$];
    acc_t acc[$];

    jtcps1_prog_merge #(.AW(AW), .FIFO_LG(2), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_bank   (prog_bank),
        .prog_we     (prog_we),
        .sdram_ack   (sdram_ack),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_dsn      (wr_dsn),
        .wr_bank     (wr_bank),
        .wr_ack      (wr_ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Controller model: drives wr_ack just after each edge in automatic modes
    always @(posedge clk) begin
        #1;
        if (ack_mode == 1)      wr_ack = ($urandom_range(3) != 0);
        else if (ack_mode == 2) wr_ack = 1'b1;
    end

    // Record every SDRAM write the controller takes (pop at the coming edge)
    always @(negedge clk) begin
        if (rst_n && wr_req && wr_ack) got.push_back('{wr_addr, wr_bank, wr_data, wr_dsn});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until sdram_ack or the bound expires
    task automatic send_byte(input logic [AW-1:0] a, input logic [1:0] bk, input logic [7:0] d,
                             input logic [1:0] m, input int bound, output bit ok);
        prog_addr = a; prog_bank = bk; prog_data = d; prog_mask = m; prog_we = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (sdram_ack) begin ok = 1'b1; break; end
        end
        if (ok) acc.push_back('{a, bk, d, m, cyc});
        prog_we = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic pop_one();
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; downloading = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (sdram_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b want=0", sdram_ack); end
        n_checks++; if (wr_req !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_req got=%b want=0", wr_req); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (wr_data !== 16'h0)  begin n_fail++; $display("FAIL reset_wr_data got=%h want=0000", wr_data); end
        n_checks++; if (wr_addr !== '0)     begin n_fail++; $display("FAIL reset_wr_addr got=%h want=0", wr_addr); end
        downloading = 1'b1;
        tick();
    endtask

    task automatic test_merge();
        bit ok1, ok2;
        ack_mode = 0; wr_ack = 1'b0; got.delete();
        send_byte(22'h00100, 2'd1, 8'hA5, 2'b10, 20, ok1);
        send_byte(22'h00100, 2'd1, 8'h3C, 2'b01, 20, ok2);
        n_checks++; if ({ok1, ok2} !== 2'b11) begin n_fail++; $display("FAIL merge_accept got=%b want=11", {ok1, ok2}); end
        n_checks++; if (wr_req !== 1'b1) begin n_fail++; $display("FAIL merge_latency wr_req got=%b want=1", wr_req); end
        n_checks++;
        if ({wr_addr, wr_bank, wr_data, wr_dsn} !== {22'h00100, 2'd1, 16'h3CA5, 2'b00}) begin
            n_fail++; $display("FAIL merge_word got=%h/%0d/%h/%b want=00100/1/3ca5/00", wr_addr, wr_bank, wr_data, wr_dsn);
        end
        pop_one();
        n_checks++; if (busy !== 1'b0 || got.size() != 1) begin n_fail++; $display("FAIL merge_single busy=%b writes=%0d want 0/1", busy, got.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        int first = -1;
        ack_mode = 0; wr_ack = 1'b0;
        send_byte(22'h2, 2'd0, 8'h7E, 2'b10, 20, ok);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            tick();
            if (wr_req && first < 0) first = k;
        end
        n_checks++; if (first != TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_latency got=%0d want=%0d", first, TIMEOUT + 1); end
        n_checks++;
        if ({wr_addr, wr_data, wr_dsn} !== {22'h2, 16'h007E, 2'b10}) begin
            n_fail++; $display("FAIL timeout_word got=%h/%h/%b want=2/007e/10", wr_addr, wr_data, wr_dsn);
        end
        pop_one();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle busy got=%b want=0", busy); end
    endtask

    task automatic test_partial();
        bit ok;
        ack_mode = 0; wr_ack = 1'b0;
        send_byte(22'h4, 2'd2, 8'h11, 2'b10, 20, ok);
        send_byte(22'h8, 2'd2, 8'h22, 2'b01, 20, ok);
        n_checks++;
        if ({wr_req, wr_addr, wr_data, wr_dsn} !== {1'b1, 22'h4, 16'h0011, 2'b10}) begin
            n_fail++; $display("FAIL partial_push got=%b/%h/%h/%b want=1/4/0011/10", wr_req, wr_addr, wr_data, wr_dsn);
        end
        downloading = 1'b0; wr_ack = 1'b1;
        tick();
        n_checks++;
        if ({wr_req, wr_addr, wr_data, wr_dsn} !== {1'b1, 22'h8, 16'h2200, 2'b01}) begin
            n_fail++; $display("FAIL partial_flush got=%b/%h/%h/%b want=1/8/2200/01", wr_req, wr_addr, wr_data, wr_dsn);
        end
        tick();
        wr_ack = 1'b0;
        n_checks++; if ({wr_req, busy} !== 2'b00) begin n_fail++; $display("FAIL partial_drain req/busy got=%b want=00", {wr_req, busy}); end
        downloading = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n_ok = 0;
        wr_t exp[$];
        ack_mode = 0; wr_ack = 1'b0; got.delete();
        for (int p = 0; p < 10; p++) exp.push_back('{22'h40 + 22'(p), 2'd3, {8'(p), 8'(p + 100)}, 2'b00});
        for (int b = 0; b < 8; b++) begin
            send_byte(22'h40 + 22'(b / 2), 2'd3, (b % 2) ? 8'(b / 2) : 8'(b / 2 + 100), (b % 2) ? 2'b01 : 2'b10, 20, ok);
            if (ok) n_ok++;
        end
        send_byte(22'h44, 2'd3, 8'd104, 2'b10, 30, ok);
        n_checks++; if (n_ok != 8 || ok) begin n_fail++; $display("FAIL stall accepted=%0d ninth=%b want 8/0", n_ok, ok); end
        ack_mode = 2;
        for (int b = 8; b < 20; b++) begin
            send_byte(22'h40 + 22'(b / 2), 2'd3, (b % 2) ? 8'(b / 2) : 8'(b / 2 + 100), (b % 2) ? 2'b01 : 2'b10, 50, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL drain_accept byte=%0d got=0 want=1", b); end
        end
        wait_idle(100, ok);
        ack_mode = 0; wr_ack = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL drain_idle busy got=1 want=0"); end
        n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL drain_count got=%0d want=10", got.size()); end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL drain_order idx=%0d got=%h want=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_we_hold();
        int  pulses = 0, dbl = 0;
        logic prev = 1'b0;
        ack_mode = 0; wr_ack = 1'b0; got.delete();
        prog_addr = 22'h30; prog_bank = 2'd0; prog_data = 8'hAA; prog_mask = 2'b10; prog_we = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sdram_ack) begin
                if (prev) dbl++;
                pulses++;
                if (pulses == 1) begin prog_data = 8'hBB; prog_mask = 2'b01; end
                if (pulses == 2) prog_we = 1'b0;
            end
            prev = sdram_ack;
        end
        prog_we = 1'b0;
        n_checks++; if (pulses != 2 || dbl != 0) begin n_fail++; $display("FAIL hold_pulses got=%0d dbl=%0d want 2/0", pulses, dbl); end
        n_checks++;
        if ({wr_req, wr_data, wr_dsn} !== {1'b1, 16'hBBAA, 2'b00}) begin
            n_fail++; $display("FAIL hold_word got=%b/%h/%b want=1/bbaa/00", wr_req, wr_data, wr_dsn);
        end
        pop_one();
        repeat (2) tick();
        n_checks++; if (got.size() != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_dup writes=%0d busy=%b want 1/0", got.size(), busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ack_mode = 0; wr_ack = 1'b0;
        for (int p = 0; p < 3; p++) begin
            send_byte(22'h60 + 22'(p), 2'd1, 8'h10, 2'b10, 20, ok);
            send_byte(22'h60 + 22'(p), 2'd1, 8'h20, 2'b01, 20, ok);
        end
        n_checks++; if ({wr_req, busy} !== 2'b11) begin n_fail++; $display("FAIL rst_pre req/busy got=%b want=11", {wr_req, busy}); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({wr_req, busy, sdram_ack} !== 3'b000) begin n_fail++; $display("FAIL rst_async req/busy/ack got=%b want=000", {wr_req, busy, sdram_ack}); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if ({wr_req, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_release req/busy got=%b want=00", {wr_req, busy}); end
        send_byte(22'h70, 2'd2, 8'h01, 2'b10, 20, ok);
        send_byte(22'h70, 2'd2, 8'h02, 2'b01, 20, ok);
        n_checks++;
        if ({wr_req, wr_addr, wr_data} !== {1'b1, 22'h70, 16'h0201}) begin
            n_fail++; $display("FAIL rst_clean head got=%b/%h/%h want=1/70/0201", wr_req, wr_addr, wr_data);
        end
        pop_one();
    endtask

    // Random streams against a transaction-level model of merge/flush rules
    task automatic test_random();
        bit ok;
        int gap;
        wr_t exp[$];
        bit pv = 1'b0;
        wr_t pend;
        int  plast = 0;
        logic [15:0] nd;
        ack_mode = 1; got.delete(); acc.delete();
        for (int n = 0; n < 80; n++) begin
            gap = ($urandom_range(9) == 0) ? 20 : $urandom_range(3);
            repeat (gap) tick();
            send_byte(22'h10 + 22'($urandom_range(1)), 2'($urandom_range(1)), 8'($urandom),
                      $urandom_range(1) ? 2'b10 : 2'b01, 100, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_accept n=%0d got=0 want=1", n); end
        end
        downloading = 1'b0;
        wait_idle(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_idle busy got=1 want=0"); end
        ack_mode = 0; wr_ack = 1'b0; downloading = 1'b1;
        foreach (acc[i]) begin
            nd = (acc[i].mask == 2'b10) ? {8'h00, acc[i].d} : {acc[i].d, 8'h00};
            if (pv && (acc[i].cyc - plast) >= TIMEOUT + 2) begin exp.push_back(pend); pv = 1'b0; end
            if (pv && pend.addr == acc[i].addr && pend.bank == acc[i].bank && (pend.dsn & acc[i].mask) == 2'b00) begin
                exp.push_back('{pend.addr, pend.bank, pend.data | nd, 2'b00});
                pv = 1'b0;
            end else begin
                if (pv) exp.push_back(pend);
                pend = '{acc[i].addr, acc[i].bank, nd, acc[i].mask};
                pv = 1'b1;
            end
            plast = acc[i].cyc;
        end
        if (pv) exp.push_back(pend);
        n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rand_word idx=%0d got=%h want=%h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_merge();
        test_timeout();
        test_partial();
        test_back_to_back();
        test_we_hold();
        test_reset_mid();
        test_random();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
